// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers the FSM state encoding, access geometry and counter sizing.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam int unsigned DW_BYTES   = 8;
    localparam logic [2:0]  ALIGN_MASK = 3'b111;
    localparam int unsigned CNT_W      = 4;

    function automatic logic is_misaligned(input logic [2:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );

endinterface

// File: rtl/dmem_array.sv
// Byte-addressed doubleword storage: synchronous little-endian write port and
// combinational read port, both indexed by doubleword. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-4:0] widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-4:0] ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DW_BYTES; i++) begin
                mem_q[{widx_i, 3'(i)}] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DW_BYTES; i++) begin
            rdata_o[8*i +: 8] = mem_q[{ridx_i, 3'(i)}];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one doubleword access in IDLE,
// stalls the pipeline while it is outstanding and commits on entry to RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LATENCY = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    dmem_responder_if.slave   bus_io
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              commit;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_misaligned;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        c_write = write_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    write_d = bus_io.req_write;
                    addr_d  = bus_io.req_addr;
                    wdata_d = bus_io.req_wdata;
                    if (LATENCY > 1) begin
                        state_d = StWait;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        // Single-cycle latency commits straight from the bus.
                        state_d = StResp;
                        commit  = 1'b1;
                        c_write = bus_io.req_write;
                        c_addr  = bus_io.req_addr;
                        c_wdata = bus_io.req_wdata;
                    end
                end
            end
            StWait: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response registers hold zero except in the cycle after a commit.
    always_comb begin
        c_misaligned = is_misaligned(c_addr[2:0]);
        mem_we       = commit && c_write && !c_misaligned && !reset_i;
        rdata_d      = '0;
        err_d        = 1'b0;
        if (commit) begin
            err_d = c_misaligned;
            if (!c_misaligned && !c_write) begin
                rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .widx_i  (c_addr[ADDR_W-1:3]),
        .wdata_i (c_wdata),
        .ridx_i  (c_addr[ADDR_W-1:3]),
        .rdata_o (mem_rdata)
    );

    assign bus_io.req_ready  = (state_q == StIdle);
    assign bus_io.resp_valid = (state_q == StResp);
    assign bus_io.resp_rdata = rdata_q;
    assign bus_io.resp_err   = err_q;
    assign bus_io.stall      = ((state_q == StIdle) && bus_io.req_valid) || (state_q == StWait);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at LATENCY 1, 2, 4 and 5 checked
// against a byte-array memory model and the latency/stall timing rules.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vld;
    logic        wr_s;
    logic [9:0]  addr_s;
    logic [63:0] wd_s;
    logic [3:0]  rdy, rv, er, stl;
    logic [63:0] rd [4];

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [7:0]  mdl [4][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if #(.ADDR_W(10), .DATA_W(64)) if0 ();
    dmem_responder #(.ADDR_W(10), .DATA_W(64), .LATENCY(1)) dut0 (
        .clk_i(clk), .reset_i(reset), .bus_io(if0));
    assign if0.req_valid = vld[0];
    assign if0.req_write = wr_s;
    assign if0.req_addr  = addr_s;
    assign if0.req_wdata = wd_s;
    assign rdy[0] = if0.req_ready;
    assign rv[0]  = if0.resp_valid;
    assign er[0]  = if0.resp_err;
    assign stl[0] = if0.stall;
    assign rd[0]  = if0.resp_rdata;

    dmem_responder_if #(.ADDR_W(10), .DATA_W(64)) if1 ();
    dmem_responder #(.ADDR_W(10), .DATA_W(64), .LATENCY(2)) dut1 (
        .clk_i(clk), .reset_i(reset), .bus_io(if1));
    assign if1.req_valid = vld[1];
    assign if1.req_write = wr_s;
    assign if1.req_addr  = addr_s;
    assign if1.req_wdata = wd_s;
    assign rdy[1] = if1.req_ready;
    assign rv[1]  = if1.resp_valid;
    assign er[1]  = if1.resp_err;
    assign stl[1] = if1.stall;
    assign rd[1]  = if1.resp_rdata;

    dmem_responder_if #(.ADDR_W(10), .DATA_W(64)) if2 ();
    dmem_responder #(.ADDR_W(10), .DATA_W(64), .LATENCY(4)) dut2 (
        .clk_i(clk), .reset_i(reset), .bus_io(if2));
    assign if2.req_valid = vld[2];
    assign if2.req_write = wr_s;
    assign if2.req_addr  = addr_s;
    assign if2.req_wdata = wd_s;
    assign rdy[2] = if2.req_ready;
    assign rv[2]  = if2.resp_valid;
    assign er[2]  = if2.resp_err;
    assign stl[2] = if2.stall;
    assign rd[2]  = if2.resp_rdata;

    dmem_responder_if #(.ADDR_W(10), .DATA_W(64)) if3 ();
    dmem_responder #(.ADDR_W(10), .DATA_W(64), .LATENCY(5)) dut3 (
        .clk_i(clk), .reset_i(reset), .bus_io(if3));
    assign if3.req_valid = vld[3];
    assign if3.req_write = wr_s;
    assign if3.req_addr  = addr_s;
    assign if3.req_wdata = wd_s;
    assign rdy[3] = if3.req_ready;
    assign rv[3]  = if3.resp_valid;
    assign er[3]  = if3.resp_err;
    assign stl[3] = if3.stall;
    assign rd[3]  = if3.resp_rdata;

    function automatic int lat(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [63:0] mload(input int k, input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mdl[k][a + i];
        return r;
    endfunction

    task automatic mstore(input int k, input int a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) mdl[k][a + i] = d[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_ready", 64'(rdy[k]), 64'd1);
        chk("rst_resp_valid", 64'(rv[k]), 64'd0);
        chk("rst_rdata", rd[k], 64'd0);
        chk("rst_err", 64'(er[k]), 64'd0);
        chk("rst_stall", 64'(stl[k]), 64'd0);
    endtask

    // One access on instance k; returns at mid-cycle of the response cycle.
    task automatic access(input int k, input logic w, input logic [9:0] a,
                          input logic [63:0] d, input bit hold, output int unsigned acc_cyc);
        int          lat_seen, stall_n, nrdy;
        bit          got;
        logic        exp_err;
        logic [63:0] exp_rd;
        exp_err = (a % 8) != 0;
        exp_rd  = (exp_err || w) ? 64'd0 : mload(k, int'(a));
        @(negedge clk);
        wr_s = w; addr_s = a; wd_s = d; vld[k] = 1'b1;
        #1;
        chk("accept_ready", 64'(rdy[k]), 64'd1);
        chk("accept_stall", 64'(stl[k]), 64'd1);
        acc_cyc  = cyc;
        stall_n  = 1;
        nrdy     = 0;
        lat_seen = 0;
        got      = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (stl[k]) stall_n++;
            if (!rdy[k]) nrdy++;
            if (rv[k]) begin
                got      = 1'b1;
                lat_seen = i;
                chk("resp_err", 64'(er[k]), 64'(exp_err));
                if (!w) chk("resp_rdata", rd[k], exp_rd);
            end
            // Request fields must be ignored while the access is outstanding.
            wr_s = 1'($urandom); addr_s = 10'($urandom); wd_s = {$urandom, $urandom};
        end
        chk("latency", 64'(lat_seen), 64'(lat(k)));
        chk("stall_cycles", 64'(stall_n), 64'(lat(k)));
        chk("ready_low_cycles", 64'(nrdy), 64'(lat(k)));
        if (w && !exp_err) mstore(k, int'(a), d);
        if (!hold) vld[k] = 1'b0;
    endtask

    initial begin
        int unsigned c0, cx;
        logic [63:0] dold, dnew;
        logic [9:0]  ra;

        reset = 1'b1; vld = '0; wr_s = 1'b0; addr_s = '0; wd_s = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk_reset_outputs(k);
        reset = 1'b0;

        // Preload doublewords 0x000..0x07F on every instance.
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++)
                access(k, 1'b1, 10'(j * 8), {$urandom, $urandom}, 1'b0, cx);

        access(1, 1'b1, 10'h010, 64'h1122334455667788, 1'b0, cx);
        access(1, 1'b0, 10'h010, 64'd0, 1'b0, cx);
        chk("byte_0x010", 64'(mdl[1][16]), 64'h88);

        access(0, 1'b1, 10'h020, 64'hA5A5_0000_1234_5678, 1'b0, cx);
        access(0, 1'b0, 10'h020, 64'd0, 1'b0, cx);
        access(3, 1'b1, 10'h028, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, cx);
        access(3, 1'b0, 10'h028, 64'd0, 1'b0, cx);

        access(1, 1'b0, 10'h013, 64'd0, 1'b0, cx);
        access(1, 1'b1, 10'h013, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, cx);
        access(1, 1'b0, 10'h010, 64'd0, 1'b0, cx);

        access(1, 1'b1, 10'h040, 64'h0101_0101_0101_0101, 1'b1, c0);
        access(1, 1'b1, 10'h048, 64'h0202_0202_0202_0202, 1'b1, cx);
        access(1, 1'b1, 10'h050, 64'h0303_0303_0303_0303, 1'b0, cx);
        chk("b2b_total_cycles", 64'(cyc - c0 + 1), 64'(3 * (lat(1) + 1)));
        access(1, 1'b0, 10'h040, 64'd0, 1'b0, cx);
        access(1, 1'b0, 10'h048, 64'd0, 1'b0, cx);
        access(1, 1'b0, 10'h050, 64'd0, 1'b0, cx);

        // Reset two edges after a store is accepted on the LATENCY=4 instance.
        dold = 64'h0BAD_F00D_1357_9BDF;
        dnew = 64'h7777_6666_5555_4444;
        access(2, 1'b1, 10'h3F8, dold, 1'b0, cx);
        @(negedge clk);
        wr_s = 1'b1; addr_s = 10'h3F8; wd_s = dnew; vld[2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_stall", 64'(stl[2]), 64'd1);
        chk("wait_ready", 64'(rdy[2]), 64'd0);
        vld[2] = 1'b0;
        reset  = 1'b1;
        #1;
        chk_reset_outputs(2);
        @(negedge clk);
        reset = 1'b0;
        access(2, 1'b0, 10'h3F8, 64'd0, 1'b0, cx);

        access(1, 1'b1, 10'h3F8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, cx);
        access(1, 1'b0, 10'h3F8, 64'd0, 1'b0, cx);
        access(1, 1'b0, 10'h000, 64'd0, 1'b0, cx);

        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 15; n++) begin
                ra = 10'($urandom_range(0, 15) * 8);
                if ($urandom_range(0, 3) == 0) ra = ra + 10'($urandom_range(1, 7));
                access(k, 1'($urandom), ra, {$urandom, $urandom}, 1'b0, cx);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. The MEM stage issues load/store requests over a valid/ready handshake, and this block services them with a fixed, parameterised latency. It drives a stall to the hazard unit while an access is outstanding and returns load data with a one-cycle response pulse. It replaces the zero-latency data memory so that the pipeline is exercised against realistic multi-cycle memory timing.

## Interface
- `ADDR_W`, default 10: byte-address width; storage is 2^ADDR_W bytes.
- `DATA_W`, default 64: doubleword width; the only access size.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`; legal values are 1 to 15.

Ports:
- `clk` input 1: single clock; everything is rising-edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present from the MEM stage.
- `req_ready` output 1: responder can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input DATA_W: store data.
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output DATA_W: load data, valid only with `resp_valid`.
- `resp_err` output 1: misaligned access flag, valid only with `resp_valid`.
- `stall` output 1: freeze the pipeline (PC, IF_ID, ID_EX, EX_MEM).

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - When `req_valid` is high, capture `req_write`, `req_addr` and `req_wdata`.
  - Go to WAIT with `cnt` = LATENCY-1 if LATENCY > 1; otherwise go directly to RESP.
- **WAIT**
  - `req_ready` = 0.
  - `cnt` decrements each cycle.
  - When `cnt` == 1 on a clock edge, go to RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - `req_ready` = 0.
  - The next request cannot be accepted before the following cycle.
- **Commit point:** the store writes to the array, and load data is read from it, on the edge that enters RESP. Outputs are registered.
- **Byte order:** little-endian. Byte `addr+i` holds `data[8i+7:8i]`.
- **Misaligned access** (`addr[2:0]` != 0): no write, `resp_rdata` = 0, `resp_err` = 1. Latency is unchanged.
- **Address range:** addresses never wrap. An aligned address always fits entirely, because the top doubleword starts at 2^ADDR_W-8.
- **stall** = (IDLE and `req_valid`) or WAIT.
  - It is 0 in RESP, so the pipeline advances in the same cycle the data is presented.
  - The MEM stage holds its request stable while `stall` is high.
  - The MEM stage must deassert `req_valid` (or present a new request) in the cycle after RESP.
- **No back-pressure on responses:** the consumer always takes the data in the RESP cycle.
- **Storage:** array contents are not reset.

## Timing
- **Reset values:** state = IDLE, `cnt` = 0, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `stall` = 0.
- **Latency:** if a request is accepted on edge k, then `resp_valid` is high in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
- **stall duration:** high for exactly LATENCY cycles per access, counting the accept cycle.
- **Throughput:** one access per LATENCY+1 cycles at most.
- **Reset mid-operation:** asserting `reset` in WAIT or RESP abandons the access.
  - A store that has not yet reached RESP is not written.
  - A store already committed at RESP entry stays written.
  - Outputs return to their reset values asynchronously.
- **Input sampling:** `req_*` are ignored outside IDLE; a change while stalled has no effect.

## Structure
- **Package `dmem_pkg`:**
  - State enum (IDLE, WAIT, RESP).
  - `DW_BYTES` = 8.
  - Alignment mask `3'b111`.
  - Counter width (4 bits).
- **Sub-module `dmem_array`:**
  - Byte-addressed synchronous storage: one write port and one read port, doubleword access, enabled by the FSM at RESP entry.
- **Top level:** the top contains only the FSM, counter, capture registers and output registers.

## Test plan
- **Store then load, LATENCY=2:**
  - Stimulus: store 0x1122334455667788 at address 0x010, then load 0x010.
  - Required response: `resp_rdata` = 0x1122334455667788, `resp_err` = 0; byte 0x010 = 0x88.
  - Required timing: `stall` high for 2 cycles per access.
- **Latency sweep, LATENCY=1 and LATENCY=5:**
  - Required response: `resp_valid` 1 and 5 cycles after accept respectively.
  - Required timing: `req_ready` low for exactly LATENCY cycles.
- **Misaligned load at 0x013:**
  - Required response: `resp_err` = 1, `resp_rdata` = 0.
  - A following misaligned store at 0x013 leaves 0x010..0x017 unchanged.
- **Back-to-back, `req_valid` held high:**
  - Stimulus: three stores issued back to back.
  - Required response: each accepted only in IDLE; 3·(LATENCY+1) cycles total; final loads return all three values.
- **Reset in WAIT, LATENCY=4:**
  - Stimulus: assert `reset` 2 cycles after a store to 0x3F8 is accepted.
  - Required response: outputs go to reset values immediately; a subsequent load of 0x3F8 returns the old contents.
- **Top address:**
  - Stimulus: store to 0x3F8 with 0xFFFFFFFFFFFFFFFF, then load 0x3F8.
  - Required response: returns all ones; 0x000 is unaffected (no wrap).
